alarm_sched: RTL and testbench



---
 rtl/alarm_sched_pkg.sv | 17 +
 rtl/alarm_sched_sec.sv | 29 ++
 rtl/alarm_sched.sv | 141 ++++++++++++++
 tb/tb_alarm_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_sched_pkg.sv
// Shared definitions for the alarm scheduler: state encodings reused by the
// display/controller blocks, plus the second-counter width and a terminal-count helper.
package alarm_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZE  = 2'd3;

  localparam int CNT_W = 9;

  // A period of N seconds ends on the tick that arrives while the counter holds N-1.
  function automatic logic [CNT_W-1:0] term_of(input int secs);
    return CNT_W'(secs - 1);
  endfunction

endpackage

// File: rtl/alarm_sched_sec.sv
// sec_timer: 9-bit seconds counter with synchronous clear and a terminal-count
// compare; done flags the tick that completes the programmed period.
module sec_timer
  import alarm_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Saturate rather than wrap so a stuck tick can never alias a short period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = tick && (cnt == term);

endmodule

// File: rtl/alarm_sched.sv
// Alarm scheduler: edge-detects time == alarm and sequences ring / snooze / timeout.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sched
  import alarm_sched_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sec_tick,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [5:0] i_alarm_sec,
  input  logic [5:0] i_alarm_min,
  input  logic       i_alarm_en,
  input  logic       i_snooze,
  input  logic       i_stop,
  output logic       o_buzz_en,
  output logic [1:0] o_state,
  output logic [2:0] o_snooze_cnt,
  output logic       o_timeout
);

  localparam logic [CNT_W-1:0] RING_TERM = term_of(RING_SEC);
  localparam logic [CNT_W-1:0] SNZ_TERM  = term_of(SNOOZE_SEC);
  localparam logic [2:0]       MAX_SNZ   = 3'(MAX_SNOOZE);

  logic [1:0] state, state_nx;
  logic [2:0] snz_cnt_nx;
  logic       timeout_nx;
  logic       match, match_d, trigger;
  logic       ring_clr, ring_done;
  logic       snz_clr, snz_done, snooze_ok;

  assign match   = (i_sec == i_alarm_sec) && (i_min == i_alarm_min);
  assign trigger = match && !match_d;

  sec_timer u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ring_clr),
    .tick  (i_sec_tick && (state == ST_RINGING)),
    .term  (RING_TERM),
    .done  (ring_done)
  );

`ifdef ALARM_SNOOZE_EN
  sec_timer u_snz (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (snz_clr),
    .tick  (i_sec_tick && (state == ST_SNOOZE)),
    .term  (SNZ_TERM),
    .done  (snz_done)
  );

  assign snooze_ok = i_snooze && (o_snooze_cnt < MAX_SNZ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_snooze_cnt <= '0;
    end else begin
      o_snooze_cnt <= snz_cnt_nx;
    end
  end
`else
  logic unused_snooze;

  assign snz_done      = 1'b0;
  assign snooze_ok     = 1'b0;
  assign o_snooze_cnt  = '0;
  assign unused_snooze = ^{i_snooze, snz_clr, snz_cnt_nx, SNZ_TERM, MAX_SNZ};
`endif

  // Branch order encodes event priority: disable > stop > snooze > tick/timeout.
  always_comb begin
    state_nx   = state;
    snz_cnt_nx = o_snooze_cnt;
    timeout_nx = 1'b0;
    ring_clr   = 1'b0;
    snz_clr    = 1'b0;
    if (!i_alarm_en) begin
      state_nx   = ST_IDLE;
      snz_cnt_nx = '0;
      ring_clr   = 1'b1;
      snz_clr    = 1'b1;
    end else begin
      case (state)
        ST_IDLE:  state_nx = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_nx   = ST_RINGING;
            ring_clr   = 1'b1;
            snz_cnt_nx = '0;
          end
        end
        ST_RINGING: begin
          if (i_stop) begin
            state_nx = ST_ARMED;
          end else if (snooze_ok) begin
            state_nx   = ST_SNOOZE;
            snz_cnt_nx = o_snooze_cnt + 3'd1;
            snz_clr    = 1'b1;
          end else if (ring_done) begin
            state_nx   = ST_ARMED;
            timeout_nx = 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (i_stop) begin
            state_nx = ST_ARMED;
          end else if (snz_done) begin
            state_nx = ST_RINGING;
            ring_clr = 1'b1;
          end
        end
`endif
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      match_d   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      match_d   <= match;
      o_timeout <= timeout_nx;
    end
  end

  assign o_state   = state;
  assign o_buzz_en = (state == ST_RINGING);

endmodule

// File: tb/tb_alarm_sched.sv
// Self-checking bench for alarm_sched: directed scenarios then random stimulus,
// compared each cycle against a countdown-style behavioural model.
module tb_alarm_sched;

  localparam int RING = 3;
  localparam int SNZ  = 2;
  localparam int MAXS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sec_tick = 1'b0;
  logic [5:0] i_sec = 6'd5;
  logic [5:0] i_min = 6'd0;
  logic [5:0] i_alarm_sec = 6'd5;
  logic [5:0] i_alarm_min = 6'd0;
  logic       i_alarm_en = 1'b1;
  logic       i_snooze = 1'b0;
  logic       i_stop = 1'b0;
  logic       o_buzz_en;
  logic [1:0] o_state;
  logic [2:0] o_snooze_cnt;
  logic       o_timeout;

  alarm_sched #(.RING_SEC(RING), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sec_tick   (i_sec_tick),
    .i_sec        (i_sec),
    .i_min        (i_min),
    .i_alarm_sec  (i_alarm_sec),
    .i_alarm_min  (i_alarm_min),
    .i_alarm_en   (i_alarm_en),
    .i_snooze     (i_snooze),
    .i_stop       (i_stop),
    .o_buzz_en    (o_buzz_en),
    .o_state      (o_state),
    .o_snooze_cnt (o_snooze_cnt),
    .o_timeout    (o_timeout)
  );

  always #10 clk = ~clk;

  // Model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing; periods count down to zero.
  int m_mode, m_snoozes, m_ring_left, m_snz_left;
  bit m_to, m_prev_match;
  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("state", 9'(o_state), 9'(m_mode));
    checkOutput("buzz_en", 9'(o_buzz_en), 9'(m_mode == 2));
    checkOutput("snooze_cnt", 9'(o_snooze_cnt), 9'(m_snoozes));
    checkOutput("timeout", 9'(o_timeout), 9'(m_to));
  endtask

  task automatic modelReset();
    m_mode = 0; m_snoozes = 0; m_ring_left = 0; m_snz_left = 0;
    m_to = 1'b0; m_prev_match = 1'b0;
  endtask

  task automatic modelStep();
    bit now_match, rise;
    now_match = (i_sec == i_alarm_sec) && (i_min == i_alarm_min);
    rise = now_match && !m_prev_match;
    m_prev_match = now_match;
    m_to = 1'b0;
    if (!i_alarm_en) begin
      m_mode = 0; m_snoozes = 0; m_ring_left = 0; m_snz_left = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2; m_ring_left = RING; m_snoozes = 0;
      end
    end else if (m_mode == 2) begin
      if (i_stop) m_mode = 1;
      else if (SNZ_EN && i_snooze && m_snoozes < MAXS) begin
        m_mode = 3; m_snoozes++; m_snz_left = SNZ;
      end else if (i_sec_tick) begin
        m_ring_left--;
        if (m_ring_left == 0) begin
          m_mode = 1; m_to = 1'b1;
        end
      end
    end else begin
      if (i_stop) m_mode = 1;
      else if (i_sec_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_mode = 2; m_ring_left = RING;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit en, input int sec, input bit tick, input bit snz, input bit stop);
    i_alarm_en = en;
    i_sec      = 6'(sec);
    i_sec_tick = tick;
    i_snooze   = snz;
    i_stop     = stop;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
    i_sec_tick = 1'b0;
    i_snooze   = 1'b0;
    i_stop     = 1'b0;
  endtask

  task automatic pulseReset();
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #15;
    checkAll();
    rst_n = 1'b1;

    // Enable held through reset release with a match already present: no trigger.
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);

    // Auto-timeout after RING ticks while the match persists, then no re-trigger.
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);

    // Snooze until the limit, then a simultaneous stop+snooze.
    applyStimulus(1, 6, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 1, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 1, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 1, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 1, 1);
    applyStimulus(1, 5, 0, 0, 0);

    // Disable while ringing, re-arm, then reset mid-ring.
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    pulseReset();
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0);

    // Random traffic around the alarm time.
    for (int n = 0; n < 3000; n++) begin
      i_min = ($urandom % 8 == 0) ? 6'd1 : 6'd0;
      applyStimulus(($urandom % 60) != 0, 3 + int'($urandom % 4),
                    ($urandom % 3) == 0, ($urandom % 7) == 0, ($urandom % 13) == 0);
      if ($urandom % 400 == 0) pulseReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
